// File: rtl/pe_row_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pe_row_sequencer_pkg
// Brief   : Shared accelerator types and default constants for the PE row
//           sequencer (state encoding, settle/timeout defaults).
// Revision: 1.0 - initial release
// ============================================================================
package pe_row_sequencer_pkg;

    localparam int c_def_num_row = 7;
    localparam int c_def_settle  = 2;
    localparam int c_def_timeout = 4096;
    localparam int c_timer_w     = 16;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_RST_WAIT   = 4'd1,
        S_FLUSH      = 4'd2,
        S_FLUSH_WAIT = 4'd3,
        S_LD_FLTR    = 4'd4,
        S_FLTR_WAIT  = 4'd5,
        S_LD_IFMAP   = 4'd6,
        S_IFMAP_WAIT = 4'd7,
        S_LD_PSUM    = 4'd8,
        S_PSUM_WAIT  = 4'd9,
        S_START      = 4'd10,
        S_ERROR      = 4'd11
    } seq_state_t;

endpackage : pe_row_sequencer_pkg
`default_nettype wire

// File: rtl/pe_row_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : pe_row_sequencer_if
// Brief   : Command handshake, PE-array status and per-row command pulses.
// Revision: 1.0 - initial release
// ============================================================================
interface pe_row_sequencer_if
    import pe_row_sequencer_pkg::*;
#(
    parameter int NUM_ROW = c_def_num_row
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [NUM_ROW-1:0] cmd_row_mask;
    logic [7:0]         cmd_kernel_size;
    logic               cmd_load_psum;
    logic               abort;

    logic [NUM_ROW-1:0] ram_rst_busy;
    logic [NUM_ROW-1:0] tag_busy;
    logic [NUM_ROW-1:0] kernel_busy;
    logic [NUM_ROW-1:0] ram_load_busy;
    logic [NUM_ROW-1:0] full;

    logic [NUM_ROW-1:0] flush_tag;
    logic [NUM_ROW-1:0] flush_kernel;
    logic [NUM_ROW-1:0] load_fltr;
    logic [NUM_ROW-1:0] load_ifmap;
    logic [NUM_ROW-1:0] load_psum;
    logic [NUM_ROW-1:0] start;
    logic [7:0]         kernel_size;
    logic               done;
    logic               err;

    // Controller / array side that issues commands and reports status
    modport master (
        output cmd_valid, cmd_row_mask, cmd_kernel_size, cmd_load_psum, abort,
        output ram_rst_busy, tag_busy, kernel_busy, ram_load_busy, full,
        input  cmd_ready, flush_tag, flush_kernel, load_fltr, load_ifmap,
        input  load_psum, start, kernel_size, done, err
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_row_mask, cmd_kernel_size, cmd_load_psum, abort,
        input  ram_rst_busy, tag_busy, kernel_busy, ram_load_busy, full,
        output cmd_ready, flush_tag, flush_kernel, load_fltr, load_ifmap,
        output load_psum, start, kernel_size, done, err
    );

endinterface : pe_row_sequencer_if
`default_nettype wire

// File: rtl/pe_seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : pe_seq_wait_timer
// Brief   : Per-state cycle counter giving settle-window and timeout flags.
// Revision: 1.0 - initial release
// ============================================================================
module pe_seq_wait_timer
    import pe_row_sequencer_pkg::*;
#(
    parameter int SETTLE  = c_def_settle,
    parameter int TIMEOUT = c_def_timeout
)(
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic restart,
    output logic      settle_done,
    output logic      expired
);

    localparam logic [c_timer_w-1:0] c_settle = c_timer_w'(SETTLE);
    localparam logic [c_timer_w-1:0] c_expire = c_timer_w'(TIMEOUT - 1);
    localparam logic [c_timer_w-1:0] c_max    = '1;

    logic [c_timer_w-1:0] r_count;

    // Count reads 0 on the first cycle of a state; it saturates rather than wraps
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (restart) begin
            r_count <= '0;
        end else if (r_count != c_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry fires on the TIMEOUT-th cycle in the state, so the exit edge is
    // the one where the count would reach TIMEOUT
    assign settle_done = (r_count >= c_settle);
    assign expired     = (r_count >= c_expire);

endmodule : pe_seq_wait_timer
`default_nettype wire

// File: rtl/pe_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pe_row_sequencer
// Brief   : Steps masked PE rows through flush, filter/ifmap/psum load and
//           start, waiting on array busy status between phases.
// Revision: 1.0 - initial release
// ============================================================================
module pe_row_sequencer
    import pe_row_sequencer_pkg::*;
#(
    parameter int NUM_ROW = c_def_num_row,
    parameter int SETTLE  = c_def_settle,
    parameter int TIMEOUT = c_def_timeout
)(
    input  wire logic         clk,
    input  wire logic         rstn,
    pe_row_sequencer_if.slave bus
);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [NUM_ROW-1:0] r_mask;
    logic               r_load_psum;
    logic [7:0]         r_kernel_size;

    logic               w_cmd_ready;
    logic               w_accept;
    logic               w_restart;
    logic               w_settle_done;
    logic               w_expired;
    logic               w_done;
    logic               w_err;
    logic [NUM_ROW-1:0] w_flush;
    logic [NUM_ROW-1:0] w_load_fltr;
    logic [NUM_ROW-1:0] w_load_ifmap;
    logic [NUM_ROW-1:0] w_load_psum;
    logic [NUM_ROW-1:0] w_start;

    logic [NUM_ROW-1:0] w_rst_busy;
    logic [NUM_ROW-1:0] w_flush_busy;
    logic [NUM_ROW-1:0] w_load_busy;
    logic [NUM_ROW-1:0] w_full;

    // Only rows of the latched command are allowed to stall the sequence
    assign w_rst_busy   = bus.ram_rst_busy & r_mask;
    assign w_flush_busy = (bus.tag_busy | bus.kernel_busy) & r_mask;
    assign w_load_busy  = bus.ram_load_busy & r_mask;
    assign w_full       = bus.full & r_mask;

    assign w_accept  = bus.cmd_valid && w_cmd_ready;
    assign w_restart = (w_state_nxt != r_state);

    pe_seq_wait_timer #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk         (clk),
        .rstn        (rstn),
        .restart     (w_restart),
        .settle_done (w_settle_done),
        .expired     (w_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mask        <= '0;
            r_load_psum   <= 1'b0;
            r_kernel_size <= '0;
        end else if (w_accept) begin
            r_mask        <= bus.cmd_row_mask;
            r_load_psum   <= bus.cmd_load_psum;
            r_kernel_size <= bus.cmd_kernel_size;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_ready  = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_flush      = '0;
        w_load_fltr  = '0;
        w_load_ifmap = '0;
        w_load_psum  = '0;
        w_start      = '0;

        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                // An empty mask has nothing to sequence: go straight to done
                if (bus.cmd_valid) begin
                    w_state_nxt = (bus.cmd_row_mask == '0) ? S_START : S_RST_WAIT;
                end
            end
            S_RST_WAIT: begin
                if (w_rst_busy == '0)  w_state_nxt = S_FLUSH;
                else if (w_expired)    w_state_nxt = S_ERROR;
            end
            S_FLUSH: begin
                w_flush     = r_mask;
                w_state_nxt = S_FLUSH_WAIT;
            end
            S_FLUSH_WAIT: begin
                if (w_settle_done && (w_flush_busy == '0)) w_state_nxt = S_LD_FLTR;
                else if (w_expired)                        w_state_nxt = S_ERROR;
            end
            S_LD_FLTR: begin
                w_load_fltr = r_mask;
                w_state_nxt = S_FLTR_WAIT;
            end
            S_FLTR_WAIT: begin
                if (w_settle_done && (w_load_busy == '0)) w_state_nxt = S_LD_IFMAP;
                else if (w_expired)                       w_state_nxt = S_ERROR;
            end
            S_LD_IFMAP: begin
                // Hold off the ifmap load while any targeted row is full
                if (w_full == '0) begin
                    w_load_ifmap = r_mask;
                    w_state_nxt  = S_IFMAP_WAIT;
                end else if (w_expired) begin
                    w_state_nxt  = S_ERROR;
                end
            end
            S_IFMAP_WAIT: begin
                if (w_settle_done && (w_load_busy == '0)) begin
                    w_state_nxt = r_load_psum ? S_LD_PSUM : S_START;
                end else if (w_expired) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_LD_PSUM: begin
                w_load_psum = r_mask;
                w_state_nxt = S_PSUM_WAIT;
            end
            S_PSUM_WAIT: begin
                if (w_settle_done && (w_load_busy == '0)) w_state_nxt = S_START;
                else if (w_expired)                       w_state_nxt = S_ERROR;
            end
            S_START: begin
                w_start     = r_mask;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ERROR: begin
                w_err = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a command arriving in IDLE
        if (bus.abort) begin
            w_state_nxt  = S_IDLE;
            w_cmd_ready  = 1'b0;
            w_done       = 1'b0;
            w_flush      = '0;
            w_load_fltr  = '0;
            w_load_ifmap = '0;
            w_load_psum  = '0;
            w_start      = '0;
        end
    end

    assign bus.cmd_ready    = w_cmd_ready;
    assign bus.flush_tag    = w_flush;
    assign bus.flush_kernel = w_flush;
    assign bus.load_fltr    = w_load_fltr;
    assign bus.load_ifmap   = w_load_ifmap;
    assign bus.load_psum    = w_load_psum;
    assign bus.start        = w_start;
    assign bus.kernel_size  = r_kernel_size;
    assign bus.done         = w_done;
    assign bus.err          = w_err;

endmodule : pe_row_sequencer
`default_nettype wire

// File: tb/tb_pe_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pe_row_sequencer
// Brief   : Directed vector table plus hand sequences for the PE row sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pe_row_sequencer;
    import pe_row_sequencer_pkg::*;

    localparam int c_rows    = 7;
    localparam int c_settle  = 2;
    localparam int c_timeout = 64;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pe_row_sequencer_if #(.NUM_ROW(c_rows)) bus ();

    pe_row_sequencer #(
        .NUM_ROW (c_rows),
        .SETTLE  (c_settle),
        .TIMEOUT (c_timeout)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [6:0] mask;
        logic [7:0] ks;
        logic       psum;
        int         exp_lat;
        int         exp_pcyc;
    } vec_t;

    vec_t        vecs [4];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_stray  = 0;
    logic [6:0]  allowed  = '0;

    int          lat, pcyc, kf, ki, kerr, kdone, early;
    logic [41:0] por;
    logic [6:0]  acc, start_at_done;
    logic [7:0]  ks_seen, ks_done, ks_after;
    logic        fseen, ready_idle, any_done;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [6:0] pulse_or();
        return bus.flush_tag | bus.flush_kernel | bus.load_fltr |
               bus.load_ifmap | bus.load_psum | bus.start;
    endfunction

    // Rows outside the active command must never see a pulse
    always @(negedge clk) begin
        if ((pulse_or() & ~allowed) != 7'h00) n_stray++;
    end

    // Leaves the bench at the first negedge after the acceptance edge
    task automatic drive_cmd(input logic [6:0] mask, input logic [7:0] ks, input logic psum);
        @(negedge clk);
        allowed              = mask;
        bus.cmd_valid        = 1'b1;
        bus.cmd_row_mask     = mask;
        bus.cmd_kernel_size  = ks;
        bus.cmd_load_psum    = psum;
        @(negedge clk);
        bus.cmd_valid        = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid       = 1'b0;
        bus.cmd_row_mask    = '0;
        bus.cmd_kernel_size = '0;
        bus.cmd_load_psum   = 1'b0;
        bus.abort           = 1'b0;
        bus.ram_rst_busy    = '0;
        bus.tag_busy        = '0;
        bus.kernel_busy     = '0;
        bus.ram_load_busy   = '0;
        bus.full            = '0;

        vecs[0] = '{7'h7F, 8'h03, 1'b0, 14, 4};
        vecs[1] = '{7'h05, 8'h09, 1'b1, 18, 5};
        vecs[2] = '{7'h00, 8'h55, 1'b1,  1, 0};
        vecs[3] = '{7'h40, 8'hFF, 1'b0, 14, 4};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_kernel_size", bus.kernel_size, 8'h00);
        check("rst_pulses", pulse_or(), 7'h00);
        check("rst_done_err", {bus.done, bus.err}, 2'b00);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_ready", bus.cmd_ready, 1'b1);

        // Table: all busy/full low
        for (int i = 0; i < 4; i++) begin
            drive_cmd(vecs[i].mask, vecs[i].ks, vecs[i].psum);
            lat = 0; pcyc = 0; por = '0; start_at_done = '0;
            ks_seen = bus.kernel_size;
            for (int k = 1; k <= 40; k++) begin
                if (k > 1) @(negedge clk);
                if (pulse_or() != 7'h00) pcyc++;
                por |= {bus.flush_tag, bus.flush_kernel, bus.load_fltr,
                        bus.load_ifmap, bus.load_psum, bus.start};
                if (bus.done) begin
                    lat = k;
                    start_at_done = bus.start;
                    break;
                end
            end
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_kernel_size", i), ks_seen, vecs[i].ks);
            check($sformatf("v%0d_pulse_cycles", i), pcyc, vecs[i].exp_pcyc);
            check($sformatf("v%0d_pulse_values", i), por,
                  {vecs[i].mask, vecs[i].mask, vecs[i].mask, vecs[i].mask,
                   (vecs[i].psum ? vecs[i].mask : 7'h00), vecs[i].mask});
            check($sformatf("v%0d_start_with_done", i), start_at_done, vecs[i].mask);
            @(negedge clk);
            check($sformatf("v%0d_ready_after", i), bus.cmd_ready, 1'b1);
        end

        // ram_load_busy[0] held 10 cycles after the filter pulse
        drive_cmd(7'h05, 8'h04, 1'b1);
        kf = 0; ki = 0; lat = 0; acc = '0; fseen = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (fseen && (k - kf == 10)) bus.ram_load_busy = 7'h00;
            if (!fseen && bus.load_fltr != 7'h00) begin
                fseen = 1'b1;
                kf = k;
                bus.ram_load_busy = 7'h01;
            end
            if (bus.load_ifmap != 7'h00) ki = k;
            acc |= bus.load_psum;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.ram_load_busy = 7'h00;
        check("busy_fltr_cycle", kf, 6);
        check("busy_ifmap_cycle", ki, 17);
        check("busy_psum_value", acc, 7'h05);
        check("busy_latency", lat, 25);

        // Full hold times out, ERROR is sticky until abort
        bus.full = 7'h04;
        drive_cmd(7'h04, 8'h21, 1'b0);
        kerr = 0; acc = '0;
        for (int k = 1; k <= 120; k++) begin
            if (k > 1) @(negedge clk);
            acc |= bus.load_ifmap;
            if (bus.err) begin
                kerr = k;
                break;
            end
        end
        check("tmo_err_cycle", kerr, 74);
        check("tmo_no_ifmap", acc, 7'h00);
        bus.full = 7'h00;
        repeat (5) @(negedge clk);
        check("tmo_err_held", bus.err, 1'b1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        check("abort_err_clear", bus.err, 1'b0);
        check("abort_ready", bus.cmd_ready, 1'b1);
        check("abort_ks_kept", bus.kernel_size, 8'h21);

        // Reset asserted during FLTR_WAIT
        drive_cmd(7'h7F, 8'h33, 1'b0);
        repeat (7) @(negedge clk);
        check("midrst_busy_before", bus.cmd_ready, 1'b0);
        rstn = 1'b0;
        #1;
        check("midrst_pulses", pulse_or(), 7'h00);
        check("midrst_done_err", {bus.done, bus.err}, 2'b00);
        check("midrst_kernel_size", bus.kernel_size, 8'h00);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        acc = '0; any_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            acc |= pulse_or();
            any_done |= bus.done;
        end
        check("midrst_quiet", {any_done, acc}, 8'h00);
        check("midrst_ready", bus.cmd_ready, 1'b1);

        // Back-to-back with cmd_valid held high
        @(negedge clk);
        allowed             = 7'h03;
        bus.cmd_valid       = 1'b1;
        bus.cmd_row_mask    = 7'h03;
        bus.cmd_kernel_size = 8'h11;
        bus.cmd_load_psum   = 1'b0;
        early = 0; kdone = 0; ready_idle = 1'b0; ks_done = '0; ks_after = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) bus.cmd_kernel_size = 8'h22;
            if (kdone == 0) begin
                if (bus.cmd_ready) early++;
                if (bus.done) begin
                    kdone = k;
                    ks_done = bus.kernel_size;
                end
            end else if (k == kdone + 1) begin
                ready_idle = bus.cmd_ready;
            end else if (k == kdone + 2) begin
                ks_after = bus.kernel_size;
                bus.cmd_valid = 1'b0;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        check("b2b_no_early_ready", early, 0);
        check("b2b_first_done", kdone, 14);
        check("b2b_ks_first", ks_done, 8'h11);
        check("b2b_ready_idle", ready_idle, 1'b1);
        check("b2b_ks_second", ks_after, 8'h22);
        any_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done) begin
                any_done = 1'b1;
                break;
            end
        end
        check("b2b_second_done", any_done, 1'b1);

        @(negedge clk);
        check("stray_row_pulses", n_stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pe_row_sequencer
`default_nettype wire
